// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath types for the fetch stage (FETCH_SKID_BUF_EN selects skid buffer)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
    logic  valid;
  } ifid_t;

  localparam word_t NOP_INSTR = '0;

  // A bubble is an sll nop with zeroed PCs so decode sees no stale addresses
  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, npc: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - icache, hazard and IF/ID signals of the fetch stage
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  imemREN;
  word_t imemaddr;
  logic  stall;
  logic  flush;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t ifid_instr;
  word_t ifid_pc;
  word_t ifid_npc;
  logic  ifid_valid;

  modport master (
    input  ihit, iload, stall, flush, redirect, redirect_pc, halt,
    output imemREN, imemaddr, ifid_instr, ifid_pc, ifid_npc, ifid_valid
  );

  modport slave (
    output ihit, iload, stall, flush, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, ifid_instr, ifid_pc, ifid_npc, ifid_valid
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry buffer catching an icache hit that lands during a stall
module fetch_skid_buf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  i_capture,
  input  logic  i_drain,
  input  logic  i_clear,
  input  word_t i_instr,
  input  word_t i_pc,
  output logic  o_valid,
  output word_t o_instr,
  output word_t o_pc
);

  logic  r_valid;
  word_t r_instr;
  word_t r_pc;

  // Clear wins over capture: a redirect or flush makes the caught word stale
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, icache request and IF/ID register; FETCH_SKID_BUF_EN adds a skid buffer
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input logic          CLK,
  input logic          nRST,
  fetch_stage_if.master bus
);

`ifdef FETCH_SKID_BUF_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  fetch_state_t r_state, w_state_nxt;
  word_t        r_pc, w_pc_nxt;
  ifid_t        r_ifid, w_ifid_nxt;

  logic  w_skid_valid;
  word_t w_skid_instr;
  word_t w_skid_pc;
  logic  w_capture;
  logic  w_drain;
  logic  w_clear;
  word_t w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ifid_nxt  = IFID_BUBBLE;
    w_capture   = 1'b0;
    w_drain     = 1'b0;
    w_clear     = 1'b0;
    if (r_state == HALTED) begin
      w_ifid_nxt = IFID_BUBBLE;
    end else if (bus.redirect) begin
      // Redirect discards any hit and ignores halt; IF/ID only holds if stalled and not flushed
      w_pc_nxt = bus.redirect_pc;
      w_clear  = 1'b1;
      if (bus.stall && !bus.flush) begin
        w_ifid_nxt = r_ifid;
      end
    end else if (bus.flush) begin
      w_clear = 1'b1;
    end else if (bus.halt) begin
      w_state_nxt = HALTED;
      w_clear     = 1'b1;
    end else if (bus.stall) begin
      w_ifid_nxt = r_ifid;
      if (SKID_EN && bus.ihit && !w_skid_valid) begin
        w_capture = 1'b1;
        w_pc_nxt  = w_pc_plus4;
      end
    end else if (w_skid_valid) begin
      w_drain    = 1'b1;
      w_ifid_nxt = '{instr: w_skid_instr, pc: w_skid_pc, npc: w_skid_pc + 32'd4, valid: 1'b1};
    end else if (bus.ihit) begin
      w_ifid_nxt = '{instr: bus.iload, pc: r_pc, npc: w_pc_plus4, valid: 1'b1};
      w_pc_nxt   = w_pc_plus4;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= FETCH;
      r_pc    <= PC_INIT;
      r_ifid  <= IFID_BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ifid  <= w_ifid_nxt;
    end
  end

`ifdef FETCH_SKID_BUF_EN
  fetch_skid_buf u_skid (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_capture (w_capture),
    .i_drain   (w_drain),
    .i_clear   (w_clear),
    .i_instr   (bus.iload),
    .i_pc      (r_pc),
    .o_valid   (w_skid_valid),
    .o_instr   (w_skid_instr),
    .o_pc      (w_skid_pc)
  );
`else
  logic w_skid_unused;
  assign w_skid_valid  = 1'b0;
  assign w_skid_instr  = NOP_INSTR;
  assign w_skid_pc     = '0;
  assign w_skid_unused = &{1'b0, w_capture, w_drain, w_clear};
`endif

  assign bus.imemREN    = (r_state == FETCH) && !bus.stall && !w_skid_valid;
  assign bus.imemaddr   = r_pc;
  assign bus.ifid_instr = r_ifid.instr;
  assign bus.ifid_pc    = r_ifid.pc;
  assign bus.ifid_npc   = r_ifid.npc;
  assign bus.ifid_valid = r_ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage, covers both FETCH_SKID_BUF_EN builds
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_stage_if bus ();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ihit        = 1'b0;
    bus.iload       = '0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt        = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    idle_inputs();
    step();
    step();
    check("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("rst_instr", bus.ifid_instr, 32'd0);
    check("rst_pc", bus.ifid_pc, 32'd0);
    check("rst_addr", bus.imemaddr, 32'h0);

    // sequential fetch
    nrst = 1'b1;
    bus.ihit  = 1'b1;
    bus.iload = 32'h2001_0005;
    #1;
    check("first_ren", {31'd0, bus.imemREN}, 32'd1);
    check("first_addr", bus.imemaddr, 32'h0);
    step();
    check("seq_instr", bus.ifid_instr, 32'h2001_0005);
    check("seq_pc0", bus.ifid_pc, 32'h0);
    check("seq_npc0", bus.ifid_npc, 32'h4);
    check("seq_valid", {31'd0, bus.ifid_valid}, 32'd1);
    check("seq_addr4", bus.imemaddr, 32'h4);
    step();
    check("seq_pc4", bus.ifid_pc, 32'h4);
    check("seq_addr8", bus.imemaddr, 32'h8);

    // miss bubbles at PC=8
    bus.ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("miss_valid", {31'd0, bus.ifid_valid}, 32'd0);
      check("miss_instr", bus.ifid_instr, 32'd0);
      check("miss_addr", bus.imemaddr, 32'h8);
    end
    bus.ihit = 1'b1;
    step();
    check("miss_resume_pc", bus.ifid_pc, 32'h8);
    check("miss_resume_addr", bus.imemaddr, 32'hC);
    step();
    check("pc_at_10", bus.imemaddr, 32'h10);

    // redirect + flush with a simultaneous hit
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    bus.flush       = 1'b1;
    bus.iload       = 32'hDEAD_BEEF;
    step();
    check("redir_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("redir_instr", bus.ifid_instr, 32'd0);
    check("redir_addr", bus.imemaddr, 32'h40);

    // move to 0x20 for the stall test
    idle_inputs();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h20;
    step();
    check("to20_addr", bus.imemaddr, 32'h20);

    idle_inputs();
    bus.stall = 1'b1;
    bus.ihit  = 1'b1;
    bus.iload = 32'h1234_5678;
    #1;
    check("stall_ren", {31'd0, bus.imemREN}, 32'd0);
    step();
    check("stall_hold_valid", {31'd0, bus.ifid_valid}, 32'd0);
`ifdef FETCH_SKID_BUF_EN
    check("stall_skid_addr", bus.imemaddr, 32'h24);
    step();
    check("stall_skid_addr2", bus.imemaddr, 32'h24);
    check("stall_hold_valid2", {31'd0, bus.ifid_valid}, 32'd0);
    bus.stall = 1'b0;
    bus.ihit  = 1'b0;
    #1;
    check("drain_ren", {31'd0, bus.imemREN}, 32'd0);
    step();
    check("drain_pc", bus.ifid_pc, 32'h20);
    check("drain_instr", bus.ifid_instr, 32'h1234_5678);
    check("drain_npc", bus.ifid_npc, 32'h24);
    check("drain_addr", bus.imemaddr, 32'h24);
    #1;
    check("resume_ren", {31'd0, bus.imemREN}, 32'd1);
`else
    check("stall_noskid_addr", bus.imemaddr, 32'h20);
    step();
    check("stall_noskid_addr2", bus.imemaddr, 32'h20);
    check("stall_hold_valid2", {31'd0, bus.ifid_valid}, 32'd0);
    bus.stall = 1'b0;
    #1;
    check("refetch_ren", {31'd0, bus.imemREN}, 32'd1);
    step();
    check("refetch_pc", bus.ifid_pc, 32'h20);
    check("refetch_instr", bus.ifid_instr, 32'h1234_5678);
    check("refetch_addr", bus.imemaddr, 32'h24);
`endif

    // PC wrap
    idle_inputs();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    bus.ihit  = 1'b1;
    bus.iload = 32'h0000_0020;
    step();
    check("wrap_pc", bus.ifid_pc, 32'hFFFF_FFFC);
    check("wrap_npc", bus.ifid_npc, 32'h0);
    check("wrap_addr", bus.imemaddr, 32'h0);

    // halt at 0x0C
    idle_inputs();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hC;
    step();
    idle_inputs();
    bus.halt = 1'b1;
    step();
    check("halt_ren", {31'd0, bus.imemREN}, 32'd0);
    check("halt_addr", bus.imemaddr, 32'hC);
    check("halt_valid", {31'd0, bus.ifid_valid}, 32'd0);
    idle_inputs();
    bus.ihit        = 1'b1;
    bus.iload       = 32'h1111_2222;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halted_ren", {31'd0, bus.imemREN}, 32'd0);
      check("halted_addr", bus.imemaddr, 32'hC);
      check("halted_valid", {31'd0, bus.ifid_valid}, 32'd0);
    end

    // reset leaves HALTED; halt with redirect stays in FETCH
    idle_inputs();
    nrst = 1'b0;
    step();
    check("rerst_addr", bus.imemaddr, 32'h0);
    nrst = 1'b1;
    bus.halt        = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h80;
    step();
    idle_inputs();
    #1;
    check("haltredir_addr", bus.imemaddr, 32'h80);
    check("haltredir_ren", {31'd0, bus.imemREN}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined MIPS datapath. Owns the PC, issues read requests to the instruction cache, and holds the IF/ID pipeline register whose `ifid_instr` drives the control unit's `instruction` input. Honours stall and flush from hazard logic, redirects from branch/jump resolution, and stops fetching permanently after a decoded `halt`.

## Interface
- `PC_INIT`, default `32'h0000_0000`, PC value loaded on reset.
- `CLK` in 1, clock, all state updates on rising edge.
- `nRST` in 1, reset, **synchronous, active-low**.
- `ihit` in 1, icache returns valid `iload` this cycle.
- `iload` in 32, fetched instruction word.
- `imemREN` out 1, instruction read request.
- `imemaddr` out 32, fetch address; always equals the PC.
- `stall` in 1, hold PC and IF/ID.
- `flush` in 1, squash IF/ID contents.
- `redirect` in 1, load PC from `redirect_pc`.
- `redirect_pc` in 32, branch/jump target.
- `halt` in 1, decode stage holds a halt instruction.
- `ifid_instr` out 32, instruction to decode/control unit.
- `ifid_pc` out 32, PC of `ifid_instr`.
- `ifid_npc` out 32, `ifid_pc + 4`.
- `ifid_valid` out 1, IF/ID holds a real instruction.

## Operation
- States: FETCH, HALTED. Reset → FETCH. FETCH → HALTED on `halt && !redirect`. HALTED is left only by reset.
- `imemREN` = (state == FETCH) && !stall && !skid_valid. `imemaddr` = PC in both states.
- Per-cycle priority, highest first:
  - `redirect`: PC ← `redirect_pc`. Any `ihit` this cycle is discarded. Skid buffer is cleared. `halt` is ignored.
  - `flush`: IF/ID ← bubble. Flush overrides `stall`.
  - `halt` in FETCH: PC holds. IF/ID ← bubble. Go to HALTED.
  - `stall`: PC and IF/ID hold. See Configuration for behaviour when `ihit` arrives during a stall.
  - `ihit`: IF/ID ← {`iload`, PC, PC+4, valid=1}. PC ← PC+4.
  - No `ihit`: IF/ID ← bubble. PC holds.
- Bubble is defined as instr=0 (sll nop), pc=0, npc=0, valid=0.
- PC+4 is computed modulo 2^32; wrap from `32'hFFFF_FFFC` to 0 is silent.
- While in HALTED, IF/ID shows a bubble and the PC is frozen.

## Timing
- Reset values: PC=`PC_INIT`; all `ifid_*`=0; skid buffer empty.
  - In the first cycle after `nRST` is released: `imemREN`=1 and `imemaddr`=`PC_INIT`.
- Latency: an `ihit` in cycle N appears on `ifid_*` in cycle N+1. Throughput is 1 instruction/cycle when `ihit` is held high.
- All `ifid_*` outputs are registered. `imemREN` and `imemaddr` are combinational from registered state only (no input-to-output path except `stall`→`imemREN`).
- If `nRST` is asserted mid-miss or mid-stall, all state is reset at that edge. Any outstanding request is abandoned.

## Configuration
- Macro `FETCH_SKID_BUF_EN` controls a one-entry skid buffer.
- **Defined:**
  - Capture: `ihit` during `stall` (no redirect/flush) stores {`iload`, PC} in the skid buffer, sets skid_valid, and advances PC by 4.
  - `imemREN` stays 0 while skid_valid is set.
  - Drain: on the first cycle with `stall` low, IF/ID ← skid contents (valid=1) and skid_valid is cleared. Fetch resumes the next cycle.
  - `flush` or `redirect` clears skid_valid.
- **Undefined:** no buffer. `imemREN` is 0 during `stall`, `ihit` during `stall` is ignored, and the instruction is refetched once the stall releases.

## Structure
- Put in `cpu_types_pkg`:
  - `fetch_state_t` enum {FETCH, HALTED}.
  - `ifid_t` packed struct {word_t instr, pc, npc; logic valid}.
  - `localparam word_t NOP_INSTR = '0`.
- Sub-module `fetch_skid_buf` holds the skid register, skid_valid, and its capture/drain/clear logic. It is instantiated only under `FETCH_SKID_BUF_EN`.

## Test plan
- **Reset and sequential fetch:** `PC_INIT`=0, hold `ihit`=1 with `iload`=`32'h2001_0005`. Expect `imemaddr` 0,4,8. Expect `ifid_pc`=0 with `ifid_npc`=4 and `ifid_valid`=1 one cycle after the first `ihit`.
- **Miss bubble:** `ihit`=0 for 3 cycles at PC=8. Expect `ifid_valid`=0, `ifid_instr`=0, `imemaddr` held at 8. Then `ihit`=1 → `ifid_pc`=8.
- **Redirect + flush with simultaneous `ihit`:** at PC=`32'h10`, assert `redirect`=1, `redirect_pc`=`32'h40`, `flush`=1, `ihit`=1. Expect next `ifid_valid`=0 and `imemaddr`=`32'h40`; the `iload` from that cycle never appears.
- **Stall during `ihit`:** at PC=`32'h20`, `stall`=1 for 2 cycles with `ihit`=1.
  - Skid enabled: `ifid_*` held, PC=`32'h24`; after release, `ifid_pc`=`32'h20`.
  - Skid disabled: `imemREN`=0, PC=`32'h20`; refetch occurs after release.
- **Halt:** assert `halt` at PC=`32'h0C`. Expect `imemREN`=0 permanently, PC frozen at `32'h0C`, `ifid_valid`=0. Then `halt` together with `redirect` (`redirect_pc`=`32'h80`) → stays in FETCH, `imemaddr`=`32'h80`.
- **PC wrap:** PC=`32'hFFFF_FFFC` with `ihit` → `ifid_npc`=0 and next `imemaddr`=0.
